// File: rtl/sensor_conditioner.sv
// Purpose : per-channel sync + debounce + rise/fall pulses + stuck-high flag for track sensors.
// Latency : level/pulse change on the (DEBOUNCE_CYCLES+2)th edge after the raw change is first sampled.
// Backpress: none; free-running per-cycle pipeline, every channel updates every clock.
//
// Ports:
//   clk, rst_n      - system clock, asynchronous active-low reset
//   sensor_raw      - raw asynchronous sensor inputs (bit0 = S1)
//   sensor_level    - debounced level
//   sensor_rise     - one-cycle pulse on accepted 0->1
//   sensor_fall     - one-cycle pulse on accepted 1->0
//   sensor_stuck    - set after STUCK_CYCLES continuous accepted-high cycles, cleared with the fall
//   any_event       - OR of all rise and fall bits
module sensor_conditioner #(
    parameter int N_SENSORS       = 6,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SENSORS-1:0] sensor_raw,
    output logic [N_SENSORS-1:0] sensor_level,
    output logic [N_SENSORS-1:0] sensor_rise,
    output logic [N_SENSORS-1:0] sensor_fall,
    output logic [N_SENSORS-1:0] sensor_stuck,
    output logic                 any_event
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int STK_W = $clog2(STUCK_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STUCK_CYCLES);
    localparam logic [STK_W-1:0] STK_ONE  = STK_W'(1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_PEND_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_PEND_LOW  = 2'd3
    } state_t;

    // Two-flop synchronizer; r_sync2 is the clean sample the debouncers see.
    logic [N_SENSORS-1:0] r_sync1;
    logic [N_SENSORS-1:0] r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sensor_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < N_SENSORS; g++) begin : g_ch
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic [STK_W-1:0] r_stk;
        logic             r_level;
        logic             r_rise;
        logic             r_fall;
        logic             r_stuck;

        logic             w_s;
        logic             w_in_high;
        logic             w_accept_fall;
        logic [STK_W-1:0] w_stk_inc;

        assign w_s           = r_sync2[g];
        assign w_in_high     = (r_state == ST_HIGH) || (r_state == ST_PEND_LOW);
        assign w_accept_fall = (r_state == ST_PEND_LOW) && !w_s && (r_cnt == CNT_LAST);
        // Saturate so a sensor held high forever never wraps back below threshold.
        assign w_stk_inc     = (r_stk == STK_MAX) ? r_stk : (r_stk + STK_ONE);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_LOW;
                r_cnt   <= '0;
                r_stk   <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
                r_stuck <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;

                case (r_state)
                    ST_LOW: begin
                        if (w_s) begin
                            r_state <= ST_PEND_HIGH;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                    ST_PEND_HIGH: begin
                        if (!w_s) begin
                            r_state <= ST_LOW;
                            r_cnt   <= '0;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state <= ST_HIGH;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                            r_rise  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    ST_HIGH: begin
                        if (!w_s) begin
                            r_state <= ST_PEND_LOW;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                    ST_PEND_LOW: begin
                        if (w_s) begin
                            r_state <= ST_HIGH;
                            r_cnt   <= '0;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state <= ST_LOW;
                            r_cnt   <= '0;
                            r_level <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_LOW;
                        r_cnt   <= '0;
                    end
                endcase

                // Stuck count runs while the accepted level is high (a pending low
                // still counts); the flag drops on the same edge the fall is accepted.
                if (w_in_high && !w_accept_fall) begin
                    r_stk   <= w_stk_inc;
                    r_stuck <= (w_stk_inc == STK_MAX);
                end else begin
                    r_stk   <= '0;
                    r_stuck <= 1'b0;
                end
            end
        end

        assign sensor_level[g] = r_level;
        assign sensor_rise[g]  = r_rise;
        assign sensor_fall[g]  = r_fall;
        assign sensor_stuck[g] = r_stuck;
    end

    assign any_event = |(sensor_rise | sensor_fall);

endmodule

// File: tb/tb_sensor_conditioner.sv
// Purpose : directed self-checking bench for sensor_conditioner (DEBOUNCE_CYCLES=4, STUCK_CYCLES=20).
// Latency : inputs driven 1 ns after a rising edge, outputs sampled at the same point.
// Backpress: n/a.
module tb_sensor_conditioner;

    localparam int N = 6;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] sensor_raw;
    logic [N-1:0] sensor_level;
    logic [N-1:0] sensor_rise;
    logic [N-1:0] sensor_fall;
    logic [N-1:0] sensor_stuck;
    logic         any_event;

    int n_checks = 0;
    int n_fail   = 0;
    int rise_n [N];
    int fall_n [N];

    sensor_conditioner #(
        .N_SENSORS      (N),
        .DEBOUNCE_CYCLES(4),
        .STUCK_CYCLES   (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sensor_raw  (sensor_raw),
        .sensor_level(sensor_level),
        .sensor_rise (sensor_rise),
        .sensor_fall (sensor_fall),
        .sensor_stuck(sensor_stuck),
        .any_event   (any_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < N; i++) begin
            rise_n[i] = 0;
            fall_n[i] = 0;
        end
    endtask

    // Advance one edge, sample 1 ns later, and tally any pulses seen.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (sensor_rise[i]) rise_n[i]++;
            if (sensor_fall[i]) fall_n[i]++;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [7:0] chat_pat;
        int         tot;

        chat_pat = 8'b1111_0111; // applied LSB first: 1,1,1,0,1,1,1,1
        rst_n      = 1'b0;
        sensor_raw = 6'h3F;
        clr_cnt();

        // Reset holds everything low even with all inputs high.
        steps(3);
        chk("rst_level", 32'(sensor_level), 32'h0);
        chk("rst_rise",  32'(sensor_rise),  32'h0);
        chk("rst_fall",  32'(sensor_fall),  32'h0);
        chk("rst_stuck", 32'(sensor_stuck), 32'h0);
        chk("rst_any",   32'(any_event),    32'h0);

        // Release with raw held high: all channels accepted on edge 6.
        rst_n = 1'b1;
        steps(5);
        chk("rel_e5_level", 32'(sensor_level), 32'h0);
        step();
        chk("rel_e6_level", 32'(sensor_level), 32'h3F);
        chk("rel_e6_rise",  32'(sensor_rise),  32'h3F);
        chk("rel_e6_any",   32'(any_event),    32'h1);
        step();
        chk("rel_e7_rise",  32'(sensor_rise),  32'h0);
        chk("rel_e7_level", 32'(sensor_level), 32'h3F);
        // All six fall together.
        sensor_raw = 6'h00;
        steps(6);
        chk("all_fall",       32'(sensor_fall),  32'h3F);
        chk("all_fall_level", 32'(sensor_level), 32'h0);
        steps(3);

        // Glitch of 3 cycles on S1 is rejected.
        clr_cnt();
        sensor_raw[0] = 1'b1;
        steps(3);
        sensor_raw[0] = 1'b0;
        steps(8);
        chk("glitch_level", 32'(sensor_level[0]), 32'h0);
        chk("glitch_rise",  32'(rise_n[0]), 32'd0);
        chk("glitch_fall",  32'(fall_n[0]), 32'd0);

        // Minimum 4-cycle accept on S2, then fall 4 cycles later.
        clr_cnt();
        sensor_raw[1] = 1'b1;
        steps(4);
        sensor_raw[1] = 1'b0;
        step();
        chk("min_e5_level", 32'(sensor_level[1]), 32'h0);
        step();
        chk("min_e6_rise",  32'(sensor_rise),     32'h02);
        chk("min_e6_level", 32'(sensor_level[1]), 32'h1);
        chk("min_e6_any",   32'(any_event),       32'h1);
        step();
        chk("min_e7_rise",  32'(sensor_rise[1]),  32'h0);
        chk("min_e7_any",   32'(any_event),       32'h0);
        steps(2);
        chk("min_e9_level", 32'(sensor_level[1]), 32'h1);
        step();
        chk("min_e10_fall",  32'(sensor_fall),     32'h02);
        chk("min_e10_level", 32'(sensor_level[1]), 32'h0);
        step();
        chk("min_e11_fall",  32'(sensor_fall[1]),  32'h0);
        steps(4);
        chk("min_rise_cnt", 32'(rise_n[1]), 32'd1);
        chk("min_fall_cnt", 32'(fall_n[1]), 32'd1);

        // Chatter on S3 restarts the count; only the final run is accepted.
        clr_cnt();
        for (int i = 0; i < 8; i++) begin
            sensor_raw[2] = chat_pat[i];
            step();
        end
        step();
        chk("chat_e9_level", 32'(sensor_level[2]), 32'h0);
        chk("chat_e9_rise",  32'(rise_n[2]),       32'd0);
        step();
        chk("chat_e10_rise",  32'(sensor_rise),     32'h04);
        chk("chat_e10_level", 32'(sensor_level[2]), 32'h1);
        sensor_raw[2] = 1'b0;
        steps(8);
        chk("chat_rise_cnt", 32'(rise_n[2]), 32'd1);
        chk("chat_level_end", 32'(sensor_level[2]), 32'h0);

        // Stuck on S6: flag after 20 HIGH cycles, cleared with the fall.
        clr_cnt();
        sensor_raw[5] = 1'b1;
        steps(6);
        chk("stk_rise", 32'(sensor_rise), 32'h20);
        steps(19);
        chk("stk_e25", 32'(sensor_stuck[5]), 32'h0);
        step();
        chk("stk_e26", 32'(sensor_stuck), 32'h20);
        steps(10);
        chk("stk_hold", 32'(sensor_stuck[5]), 32'h1);
        sensor_raw[5] = 1'b0;
        steps(5);
        chk("stk_pend_stuck", 32'(sensor_stuck[5]), 32'h1);
        chk("stk_pend_fall",  32'(sensor_fall[5]),  32'h0);
        step();
        chk("stk_fall",       32'(sensor_fall),     32'h20);
        chk("stk_clear",      32'(sensor_stuck[5]), 32'h0);
        chk("stk_level",      32'(sensor_level[5]), 32'h0);
        steps(3);

        // Asynchronous reset while S4 is HIGH: level drops at once, no fall.
        clr_cnt();
        sensor_raw[3] = 1'b1;
        steps(6);
        chk("ar_level_hi", 32'(sensor_level[3]), 32'h1);
        steps(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_level_drop", 32'(sensor_level), 32'h0);
        chk("ar_no_fall",    32'(sensor_fall),  32'h0);
        chk("ar_no_any",     32'(any_event),    32'h0);
        sensor_raw = 6'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_cnt();
        steps(10);
        tot = 0;
        for (int i = 0; i < N; i++) tot += rise_n[i] + fall_n[i];
        chk("ar_no_events", 32'(tot), 32'd0);
        chk("ar_level_end", 32'(sensor_level), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
